// File: rtl/ps2_device_tx.sv
// Device-side PS/2 transmitter: generates the PS/2 clock and shifts out
// start/data/parity/stop frames on open-drain lines, yielding to host inhibit.
module ps2_device_tx #(
  parameter int HALF_PERIOD_CYCLES = 2000,
  parameter int IDLE_CYCLES        = 2500,
  parameter int GUARD_CYCLES       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_abort,
  output logic       busy,
  output logic       host_rts,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int PW = $clog2(HALF_PERIOD_CYCLES);
  localparam int IW = $clog2(IDLE_CYCLES + 1);
  localparam logic [PW-1:0] PHASE_LAST  = PW'(HALF_PERIOD_CYCLES - 1);
  localparam logic [PW-1:0] PHASE_MID   = PW'(HALF_PERIOD_CYCLES / 2);
  localparam logic [PW-1:0] PHASE_GUARD = PW'(GUARD_CYCLES);
  localparam logic [IW-1:0] IDLE_LAST   = IW'(IDLE_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, WAIT_BUS, BIT_HIGH, BIT_LOW, TRAIL} state_t;

  state_t        state;
  logic [1:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic          clk_s;
  logic          dat_s;
  logic [10:0]   frame;
  logic [3:0]    index;
  logic [PW-1:0] phase;
  logic [IW-1:0] idle_count;

  assign clk_s    = clk_sync[1];
  assign dat_s    = dat_sync[1];
  assign tx_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // Synchronizers reset to the released (high) bus level.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk_in};
      dat_sync <= {dat_sync[0], ps2_dat_in};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
      tx_done    <= 1'b0;
      tx_abort   <= 1'b0;
      host_rts   <= 1'b0;
      frame      <= '0;
      index      <= '0;
      phase      <= '0;
      idle_count <= '0;
    end else begin
      tx_done  <= 1'b0;
      tx_abort <= 1'b0;
      host_rts <= ((state == IDLE) || (state == WAIT_BUS)) && clk_s && !dat_s;
      case (state)
        IDLE: begin
          ps2_clk_oe <= 1'b0;
          ps2_dat_oe <= 1'b0;
          if (tx_valid) begin
            frame      <= {1'b1, ~^tx_data, tx_data, 1'b0};
            idle_count <= '0;
            state      <= WAIT_BUS;
          end
        end
        WAIT_BUS: begin
          if (clk_s && dat_s) begin
            if (idle_count == IDLE_LAST) begin
              index <= '0;
              phase <= '0;
              state <= BIT_HIGH;
            end else begin
              idle_count <= idle_count + 1'b1;
            end
          end else begin
            idle_count <= '0;
          end
        end
        // Data changes mid-way through the released phase so it is stable
        // well before the host samples on the falling clock.
        BIT_HIGH: begin
          if ((phase >= PHASE_GUARD) && !clk_s) begin
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            tx_abort   <= 1'b1;
            state      <= IDLE;
          end else begin
            if (phase == PHASE_MID) ps2_dat_oe <= ~frame[index];
            if (phase == PHASE_LAST) begin
              phase      <= '0;
              ps2_clk_oe <= 1'b1;
              state      <= BIT_LOW;
            end else begin
              phase <= phase + 1'b1;
            end
          end
        end
        BIT_LOW: begin
          if (phase == PHASE_LAST) begin
            phase      <= '0;
            ps2_clk_oe <= 1'b0;
            if (index == 4'd10) begin
              ps2_dat_oe <= 1'b0;
              state      <= TRAIL;
            end else begin
              index <= index + 1'b1;
              state <= BIT_HIGH;
            end
          end else begin
            phase <= phase + 1'b1;
          end
        end
        TRAIL: begin
          ps2_clk_oe <= 1'b0;
          ps2_dat_oe <= 1'b0;
          if (phase == PHASE_LAST) begin
            phase   <= '0;
            tx_done <= 1'b1;
            state   <= IDLE;
          end else begin
            phase <= phase + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_device_tx.sv
// Self-checking bench for ps2_device_tx: a frame-timeline model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_ps2_device_tx;

  localparam int H     = 20;
  localparam int IDLEC = 10;
  localparam int GUARD = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, tx_done, tx_abort, busy, host_rts;
  logic       ps2_clk_in, ps2_dat_in, ps2_clk_oe, ps2_dat_oe;
  logic       host_clk_low, host_dat_low;

  int n_compared   = 0;
  int n_mismatched = 0;
  int cyc          = 0;
  int rises        = 0;
  int falls        = 0;
  int accept_cyc   = 0;
  logic samples[$];

  ps2_device_tx #(
    .HALF_PERIOD_CYCLES(H),
    .IDLE_CYCLES(IDLEC),
    .GUARD_CYCLES(GUARD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx_done(tx_done),
    .tx_abort(tx_abort),
    .busy(busy),
    .host_rts(host_rts),
    .ps2_clk_in(ps2_clk_in),
    .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe)
  );

  // Open-drain bus: a line is low if either end pulls it.
  assign ps2_clk_in = ~(ps2_clk_oe | host_clk_low);
  assign ps2_dat_in = ~(ps2_dat_oe | host_dat_low);

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Host-side view: sample data whenever the device pulls the clock low.
  always @(posedge ps2_clk_oe) begin
    samples.push_back(ps2_dat_in);
    rises++;
  end
  always @(negedge ps2_clk_oe) falls++;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Frame bit k: start, eight data bits LSB first, odd parity, stop.
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (k == 9) return (($countones(b) % 2) == 0);
    return 1'b1;
  endfunction

  // Model: the frame is a timeline t counted from the end of the bus-idle wait;
  // outputs follow from t by division into bit slots of 2*H cycles.
  typedef enum {M_IDLE, M_WAIT, M_SEND} mode_t;
  mode_t m_mode = M_IDLE;
  int    m_t = 0, m_run = 0, m_bit = 0, m_w = 0;
  logic [7:0] m_byte = 8'h00;
  logic  m_h1c = 1'b1, m_h2c = 1'b1, m_h1d = 1'b1, m_h2d = 1'b1;
  logic  m_cs, m_ds, m_line_c, m_line_d;
  logic  e_clk_oe = 1'b0, e_dat_oe = 1'b0, e_done = 1'b0, e_abort = 1'b0, e_rts = 1'b0;
  bit    model_armed = 1'b0;

  always @(posedge clk) begin
    m_line_c = ~(e_clk_oe | host_clk_low);
    m_line_d = ~(e_dat_oe | host_dat_low);
    m_cs = m_h2c;
    m_ds = m_h2d;
    e_done  = 1'b0;
    e_abort = 1'b0;
    if (reset) begin
      m_mode = M_IDLE;
      m_t = 0;
      m_run = 0;
      e_rts = 1'b0;
      m_h1c = 1'b1; m_h2c = 1'b1; m_h1d = 1'b1; m_h2d = 1'b1;
      model_armed = 1'b1;
    end else begin
      e_rts = (m_mode != M_SEND) && m_cs && !m_ds;
      m_h2c = m_h1c; m_h1c = m_line_c;
      m_h2d = m_h1d; m_h1d = m_line_d;
      case (m_mode)
        M_IDLE: if (tx_valid) begin
          m_byte = tx_data;
          m_run  = 0;
          m_mode = M_WAIT;
        end
        M_WAIT: begin
          if (m_cs && m_ds) begin
            m_run++;
            if (m_run == IDLEC) begin
              m_mode = M_SEND;
              m_t = 0;
            end
          end else begin
            m_run = 0;
          end
        end
        default: begin
          m_w = m_t % (2 * H);
          if ((m_t < 22 * H) && (m_w < H) && (m_w >= GUARD) && !m_cs) begin
            e_abort = 1'b1;
            m_mode = M_IDLE;
          end else if (m_t == 23 * H - 1) begin
            e_done = 1'b1;
            m_mode = M_IDLE;
          end else begin
            m_t++;
          end
        end
      endcase
    end
    e_clk_oe = 1'b0;
    e_dat_oe = 1'b0;
    if ((m_mode == M_SEND) && (m_t < 22 * H)) begin
      m_bit = m_t / (2 * H);
      m_w   = m_t % (2 * H);
      e_clk_oe = (m_w >= H);
      if (m_w > H / 2) e_dat_oe = ~frame_bit(m_byte, m_bit);
      else if (m_bit > 0) e_dat_oe = ~frame_bit(m_byte, m_bit - 1);
    end
  end

  // Every cycle after the first reset edge the DUT must match the model.
  always @(negedge clk) begin
    if (model_armed) begin
      checkOutput("tx_ready", tx_ready, m_mode == M_IDLE);
      checkOutput("busy", busy, m_mode != M_IDLE);
      checkOutput("tx_done", tx_done, e_done);
      checkOutput("tx_abort", tx_abort, e_abort);
      checkOutput("host_rts", host_rts, e_rts);
      checkOutput("ps2_clk_oe", ps2_clk_oe, e_clk_oe);
      checkOutput("ps2_dat_oe", ps2_dat_oe, e_dat_oe);
    end
  end

  // Offer one byte for one cycle; caller sits at a falling edge.
  task automatic applyStimulus(input logic [7:0] b);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    accept_cyc = cyc;
  endtask

  task automatic wait_end(input int budget, output int dones, output int aborts,
                          output int end_cyc, output logic ready_after);
    dones = 0; aborts = 0; end_cyc = -1; ready_after = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (tx_done === 1'b1) dones++;
      if (tx_abort === 1'b1) aborts++;
      if (dones + aborts > 0) begin
        end_cyc = cyc;
        break;
      end
    end
    if (end_cyc < 0) begin
      checkOutput("frame_end_timeout", 32'd0, 32'd1);
    end else begin
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        if (i == 0) ready_after = tx_ready;
        if (tx_done === 1'b1) dones++;
        if (tx_abort === 1'b1) aborts++;
      end
    end
  endtask

  task automatic count_pulses(input int n, output int dones, output int aborts);
    dones = 0; aborts = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (tx_done === 1'b1) dones++;
      if (tx_abort === 1'b1) aborts++;
    end
  endtask

  task automatic wait_count(input string name, input bit use_falls, input int target,
                            input int budget);
    for (int i = 0; i < budget; i++) begin
      if ((use_falls ? falls : rises) >= target) return;
      @(negedge clk);
    end
    checkOutput(name, 32'd0, 32'd1);
  endtask

  function automatic logic [10:0] packed_samples();
    logic [10:0] bits;
    for (int i = 0; i < 11; i++) bits[i] = (i < samples.size()) ? samples[i] : 1'bx;
    return bits;
  endfunction

  task automatic send_frame(input logic [7:0] b, output logic [10:0] bits,
                            output int dones, output int aborts, output int latency,
                            output logic ready_after);
    int end_cyc;
    samples.delete();
    rises = 0;
    falls = 0;
    applyStimulus(b);
    wait_end(2000, dones, aborts, end_cyc, ready_after);
    latency = end_cyc - accept_cyc;
    bits = packed_samples();
  endtask

  initial begin
    logic [10:0] bits;
    int dones, aborts, latency, n;
    logic ready_after;

    reset = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
    host_clk_low = 1'b0; host_dat_low = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_tx_ready", tx_ready, 1);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_clk_oe", ps2_clk_oe, 0);
    checkOutput("reset_dat_oe", ps2_dat_oe, 0);
    checkOutput("reset_host_rts", host_rts, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // 0xA5: 10 idle cycles then 23 half-periods from acceptance to done.
    send_frame(8'hA5, bits, dones, aborts, latency, ready_after);
    checkOutput("a5_bits", bits, 11'b11101001010);
    checkOutput("a5_latency", latency, 470);
    checkOutput("a5_clk_falls", falls, 11);
    checkOutput("a5_done_pulses", dones, 1);
    checkOutput("a5_abort_pulses", aborts, 0);
    checkOutput("a5_ready_after", ready_after, 1);

    send_frame(8'h00, bits, dones, aborts, latency, ready_after);
    checkOutput("p00_bits", bits, 11'b11000000000);
    send_frame(8'h07, bits, dones, aborts, latency, ready_after);
    checkOutput("p07_parity", bits[9], 0);
    send_frame(8'hFF, bits, dones, aborts, latency, ready_after);
    checkOutput("pff_parity", bits[9], 1);

    // Host inhibit during the released phase of bit 4.
    samples.delete(); rises = 0; falls = 0;
    applyStimulus(8'h5A);
    wait_count("inhibit_wait_timeout", 1'b1, 4, 1000);
    repeat (8) @(negedge clk);
    host_clk_low = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (tx_abort === 1'b1) break;
    end
    checkOutput("abort_within_guard", n <= GUARD + 3, 1);
    checkOutput("abort_clk_released", ps2_clk_oe, 0);
    checkOutput("abort_dat_released", ps2_dat_oe, 0);
    count_pulses(6, dones, aborts);
    checkOutput("abort_no_done", dones, 0);
    host_clk_low = 1'b0;
    repeat (5) @(negedge clk);
    send_frame(8'h12, bits, dones, aborts, latency, ready_after);
    checkOutput("x12_bits", bits, 11'b11000100100);
    checkOutput("x12_done_pulses", dones, 1);

    // Host pulls the clock low during the trailing release: frame still done.
    samples.delete(); rises = 0; falls = 0;
    applyStimulus(8'hC3);
    wait_count("trail_wait_timeout", 1'b1, 11, 1000);
    repeat (3) @(negedge clk);
    host_clk_low = 1'b1;
    repeat (6) @(negedge clk);
    host_clk_low = 1'b0;
    begin
      int end_cyc;
      wait_end(100, dones, aborts, end_cyc, ready_after);
    end
    checkOutput("trail_done_pulses", dones, 1);
    checkOutput("trail_abort_pulses", aborts, 0);

    // Host request-to-send while idle, then a byte waits for the bus.
    host_dat_low = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rts_detected", host_rts, 1);
    samples.delete(); rises = 0; falls = 0;
    applyStimulus(8'h3C);
    checkOutput("rts_byte_accepted", busy, 1);
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      checkOutput("rts_clk_held", ps2_clk_oe, 0);
    end
    host_dat_low = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("rts_idle_wait", ps2_clk_oe, 0);
    end
    begin
      int end_cyc;
      wait_end(1000, dones, aborts, end_cyc, ready_after);
    end
    checkOutput("rts_done_pulses", dones, 1);
    checkOutput("rts_bits", packed_samples(), 11'b11001111000);

    // Reset during the pulled-low phase of bit 6.
    samples.delete(); rises = 0; falls = 0;
    applyStimulus(8'h81);
    wait_count("reset_wait_timeout", 1'b0, 7, 1000);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midreset_clk_oe", ps2_clk_oe, 0);
    checkOutput("midreset_dat_oe", ps2_dat_oe, 0);
    checkOutput("midreset_busy", busy, 0);
    checkOutput("midreset_tx_ready", tx_ready, 1);
    reset = 1'b0;
    count_pulses(600, dones, aborts);
    checkOutput("midreset_no_done", dones, 0);
    checkOutput("midreset_no_abort", aborts, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
